// File: rtl/std_rr_grant_scheduler.sv
// Round-robin grant scheduler with locked ownership and a registered one-hot grant plus index.
// Optional watchdog force-release enabled by defining STD_RR_GRANT_SCHEDULER_TIMEOUT_EN.
module std_rr_grant_scheduler #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N-1:0]               i_req,
  input  logic                       i_release,
  output logic [N-1:0]               o_grant,
  output logic [$clog2(N)-1:0]       o_grant_idx,
  output logic                       o_busy,
  output logic                       o_timeout
);

  localparam int unsigned IDX_WIDTH = $clog2(N);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e               state_q, state_d;
  logic [N-1:0]         grant_q, grant_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;

  logic [N-1:0]         eligible;
  logic                 win_found;
  logic [IDX_WIDTH-1:0] win_idx;
  logic                 force_rel;
  logic                 do_release;
  logic                 grant_load;

  // The releasing owner is excluded so others cannot be starved by a re-requesting owner.
  assign eligible   = (state_q == StHold) ? (i_req & ~grant_q) : i_req;
  assign do_release = i_release | force_rel;

  always_comb begin
    int unsigned k;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      k = int'(ptr_q) + i;
      if (k >= N) k = k - N;
      if (!win_found && eligible[IDX_WIDTH'(k)]) begin
        win_found = 1'b1;
        win_idx   = IDX_WIDTH'(k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    grant_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_load = 1'b1;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (do_release) begin
          if (win_found) begin
            grant_load = 1'b1;
          end else begin
            state_d = StIdle;
            grant_d = '0;
            idx_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (grant_load) begin
      grant_d          = '0;
      grant_d[win_idx] = 1'b1;
      idx_d            = win_idx;
      ptr_d            = win_idx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= IDX_WIDTH'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef STD_RR_GRANT_SCHEDULER_TIMEOUT_EN
  logic [15:0] wd_q;
  logic        timeout_q;

  // An explicit release in the same cycle wins over the watchdog.
  assign force_rel = (state_q == StHold) && !i_release && (wd_q == 16'(TIMEOUT));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= force_rel;
      if (grant_load || state_q == StIdle) begin
        wd_q <= '0;
      end else if (!i_release) begin
        wd_q <= wd_q + 16'd1;
      end
    end
  end

  assign o_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
  assign force_rel          = 1'b0;
  assign o_timeout          = 1'b0;
`endif

  assign o_grant     = grant_q;
  assign o_grant_idx = idx_q;
  assign o_busy      = |grant_q;

endmodule

// File: doc/std_rr_grant_scheduler.md
Name: std_rr_grant_scheduler

Overview:
- Round-robin scheduler sharing one downstream resource among N requesters.
- Issues a registered one-hot grant plus its binary index.
  - The index equals the binary encoding of the one-hot grant.
  - Downstream logic uses the index directly as a mux/select address.
- A grant is locked until the current owner releases the resource. The next owner is then chosen fairly, starting after the last owner.

Parameters:
- N, 4, number of requesters; legal range 2..256.
- IDX_WIDTH, $clog2(N), width of grant index; derived, not overridden.
- TIMEOUT, 16, watchdog limit in cycles; used only with the optional feature; legal range 1..65535.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset; asynchronous, active-low.
- i_req  input  N  per-requester request level; bit k = requester k.
- i_release  input  1  owner finished; sampled only while o_busy=1.
- o_grant  output  N  registered one-hot grant; all-zero when idle.
- o_grant_idx  output  IDX_WIDTH  binary index of the set o_grant bit; 0 when idle.
- o_busy  output  1  1 while a grant is held (o_grant != 0).
- o_timeout  output  1  one-cycle pulse on watchdog force-release; constant 0 without the optional feature.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - o_grant=0, o_grant_idx=0, o_busy=0, o_timeout=0, state=IDLE.
  - Last-owner pointer ptr=N-1, so requester 0 has top priority after reset.
  - Watchdog counter cleared.
- States: IDLE, HOLD.
- IDLE:
  - If i_req!=0: select winner w = first set bit scanning ptr+1, ptr+2, ... mod N.
  - Next edge: o_grant=1<<w, o_grant_idx=w, o_busy=1, ptr=w, state=HOLD.
  - Latency from request to grant is exactly 1 cycle.
  - If i_req==0: remain in IDLE; outputs stay 0.
- HOLD:
  - Grant is locked. Changes to i_req, including the owner dropping its request, do not alter o_grant.
  - i_release=1 with another request pending (i_req with owner bit masked off, !=0): next edge grants the new round-robin winner directly. There is no idle bubble, and state stays HOLD.
  - i_release=1 with the owner the only requester: next edge goes to IDLE with outputs zero. The owner may win again only via IDLE arbitration on a later cycle (no starvation of others).
  - i_release=0: hold.
- Arbitration mask on re-arbitration from HOLD excludes the releasing owner. From IDLE, all bits are eligible.
- Wrap-around: pointer arithmetic is mod N; a winner search from ptr=N-1 starts at 0.
- Invariants:
  - o_grant is always zero or one-hot.
  - o_grant_idx always equals the encoding of o_grant.
  - o_busy == |o_grant.
- i_release while IDLE is ignored.
- i_req bits at or above N do not exist; non-power-of-2 N is legal and index values >= N never appear.
- Reset asserted mid-HOLD drops the grant immediately (asynchronously); no release handshake is required.

Optional Feature:
- Macro: STD_RR_GRANT_SCHEDULER_TIMEOUT_EN.
- Enabled:
  - 16-bit watchdog counter clears on every new grant and increments each HOLD cycle without i_release.
  - When it reaches TIMEOUT, the next edge acts as an implicit release, following the same re-arbitration rules, and o_timeout pulses high for exactly that one cycle.
  - A simultaneous i_release takes precedence: normal release, no o_timeout pulse.
- Disabled:
  - No counter is generated.
  - o_timeout is tied 0.
  - HOLD persists indefinitely until i_release.

Test Plan (N=4):
1. Reset then i_req=4'b1111 → cycle+1: o_grant=0001, idx=0. Pulse i_release each time a grant appears → successive grants 0010(1), 0100(2), 1000(3), 0001(0).
2. i_req=4'b1010 from IDLE with ptr=3 → grant idx=1. Release → grant idx=3 on the very next cycle; o_busy stays 1 throughout.
3. Owner drops request while in HOLD, i_release=0 for 5 cycles → o_grant unchanged all 5 cycles. Release with i_req=0 → IDLE, o_grant=0, o_busy=0.
4. Only requester 2 active, holds and releases → IDLE for ≥1 cycle, then re-granted idx=2. Raise req 0 during that HOLD, then release → idx=0 next.
5. Assert i_rst low mid-HOLD (not on a clock edge) → o_grant=0, o_busy=0 immediately. After deassert with i_req=1111 → grant idx=0.
6. Macro defined, TIMEOUT=3, owner never releases with i_req=0011 → o_timeout=1 for one cycle and grant moves idx=0→1. Release coinciding with the limit → no o_timeout pulse.
